// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: bus command encoding and the I/O address map.
package mmio_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'd0,
        MREAD  = 2'd1,
        MWRITE = 2'd2
    } mem_cmd_t;

    localparam logic [8:0] ADDR_LED     = 9'h100;
    localparam logic [8:0] ADDR_HEX     = 9'h120;
    localparam logic [8:0] ADDR_SW      = 9'h140;
    localparam logic [8:0] ADDR_KEYSTAT = 9'h160;
    localparam logic [8:0] ADDR_CYCLE   = 9'h180;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs, with a configurable reset value.
module sync_2ff #(
    parameter int           W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// CPU data-bus I/O responder: LEDs, HEX value, switches and sticky key flags.
// Define MMIO_CYCLE_COUNTER_EN to map a free-running 16-bit cycle counter at 0x180.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int AW   = 9,
    parameter int DW   = 16,
    parameter int NKEY = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mem_cmd,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   write_data,
    input  logic [7:0]      sw_in,
    input  logic [NKEY-1:0] key_n,
    output logic            io_sel,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid,
    output logic [7:0]      led_out,
    output logic [DW-1:0]   hex_value
);

    logic [7:0]      sw_sync;
    logic [NKEY-1:0] key_sync;
    logic [NKEY-1:0] key_prev;
    logic [NKEY-1:0] key_fall;
    logic [NKEY-1:0] key_status;

    logic hit_led, hit_hex, hit_sw, hit_keystat, hit_cycle;
    logic is_read, is_write;
    logic [DW-1:0] rd_mux;

    sync_2ff #(.W(8), .RESET_VAL(8'h00)) u_sync_sw (
        .clk   (clk),
        .reset (reset),
        .d     (sw_in),
        .q     (sw_sync)
    );

    // Keys idle high, so reset to released to avoid a false press after reset.
    sync_2ff #(.W(NKEY), .RESET_VAL({NKEY{1'b1}})) u_sync_key (
        .clk   (clk),
        .reset (reset),
        .d     (key_n),
        .q     (key_sync)
    );

    assign hit_led     = (mem_addr == AW'(ADDR_LED));
    assign hit_hex     = (mem_addr == AW'(ADDR_HEX));
    assign hit_sw      = (mem_addr == AW'(ADDR_SW));
    assign hit_keystat = (mem_addr == AW'(ADDR_KEYSTAT));

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [15:0] cycle_cnt;

    assign hit_cycle = (mem_addr == AW'(ADDR_CYCLE));

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= 16'h0000;
        end else if (is_write && hit_cycle) begin
            cycle_cnt <= write_data[15:0];
        end else begin
            cycle_cnt <= cycle_cnt + 16'h0001;
        end
    end
`else
    assign hit_cycle = 1'b0;
`endif

    assign io_sel   = hit_led | hit_hex | hit_sw | hit_keystat | hit_cycle;
    assign is_read  = (mem_cmd == MREAD);
    assign is_write = (mem_cmd == MWRITE);
    assign key_fall = key_prev & ~key_sync;

    always_comb begin
        rd_mux = '0;
        if (hit_hex) begin
            rd_mux = hex_value;
        end else if (hit_sw) begin
            rd_mux = DW'(sw_sync);
        end else if (hit_keystat) begin
            rd_mux = DW'(key_status);
        end
`ifdef MMIO_CYCLE_COUNTER_EN
        else if (hit_cycle) begin
            rd_mux = DW'(cycle_cnt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_out    <= 8'h00;
            hex_value  <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            key_status <= '0;
            key_prev   <= '1;
        end else begin
            key_prev <= key_sync;
            if (is_write && hit_led) begin
                led_out <= write_data[7:0];
            end
            if (is_write && hit_hex) begin
                hex_value <= write_data;
            end
            rd_valid <= is_read && io_sel;
            if (is_read && io_sel) begin
                rd_data <= rd_mux;
            end
            // Clear-on-read, but an edge landing in the same cycle still sets its bit.
            if (is_read && hit_keystat) begin
                key_status <= key_fall;
            end else begin
                key_status <= key_status | key_fall;
            end
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed self-checking bench for mmio_responder with hand-computed expectations.
module tb_mmio_responder;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw_in;
    logic [3:0]  key_n;
    logic        io_sel;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [7:0]  led_out;
    logic [15:0] hex_value;

    int checks = 0;
    int errors = 0;

    mmio_responder dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .sw_in      (sw_in),
        .key_n      (key_n),
        .io_sel     (io_sel),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .led_out    (led_out),
        .hex_value  (hex_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        tick();
        mem_cmd    = MNONE;
        write_data = 16'h0000;
    endtask

    initial begin
        reset      = 1'b1;
        mem_cmd    = MNONE;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        sw_in      = 8'h00;
        key_n      = 4'hF;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_led", 32'(led_out), 32'h00);
        chk("rst_hex", 32'(hex_value), 32'h0000);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0000);

        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("rst_keystat_valid", 32'(rd_valid), 32'h1);
        chk("rst_keystat", 32'(rd_data), 32'h0000);

        mem_addr = ADDR_LED;
        #1;
        chk("io_sel_led", 32'(io_sel), 32'h1);
        bus(MWRITE, ADDR_LED, 16'h12A5);
        chk("led_write", 32'(led_out), 32'hA5);
        chk("led_write_no_valid", 32'(rd_valid), 32'h0);
        chk("led_write_hex_untouched", 32'(hex_value), 32'h0000);

        bus(MREAD, ADDR_LED, 16'h0000);
        chk("led_read_valid", 32'(rd_valid), 32'h1);
        chk("led_read_zero", 32'(rd_data), 32'h0000);

        bus(MWRITE, ADDR_HEX, 16'hBEEF);
        chk("hex_write", 32'(hex_value), 32'hBEEF);
        chk("hex_write_led_untouched", 32'(led_out), 32'hA5);
        bus(MREAD, ADDR_HEX, 16'h0000);
        chk("hex_read1_valid", 32'(rd_valid), 32'h1);
        chk("hex_read1", 32'(rd_data), 32'hBEEF);
        bus(MREAD, ADDR_HEX, 16'h0000);
        chk("hex_read2_valid", 32'(rd_valid), 32'h1);
        chk("hex_read2", 32'(rd_data), 32'hBEEF);
        tick();
        chk("valid_one_cycle", 32'(rd_valid), 32'h0);

        // Command 3 behaves as no command.
        bus(2'd3, ADDR_LED, 16'h0011);
        chk("cmd3_led", 32'(led_out), 32'hA5);
        chk("cmd3_valid", 32'(rd_valid), 32'h0);

        bus(MWRITE, ADDR_SW, 16'h00FF);
        chk("sw_store_ignored_led", 32'(led_out), 32'hA5);

        sw_in = 8'h3C;
        tick();
        tick();
        tick();
        bus(MREAD, ADDR_SW, 16'h0000);
        chk("sw_read_valid", 32'(rd_valid), 32'h1);
        chk("sw_read", 32'(rd_data), 32'h003C);

        mem_addr = 9'h1F0;
        #1;
        chk("unmapped_io_sel", 32'(io_sel), 32'h0);
        bus(MWRITE, 9'h1F0, 16'hFFFF);
        chk("unmapped_wr_led", 32'(led_out), 32'hA5);
        chk("unmapped_wr_hex", 32'(hex_value), 32'hBEEF);
        chk("unmapped_wr_valid", 32'(rd_valid), 32'h0);
        bus(MREAD, 9'h1F0, 16'h0000);
        chk("unmapped_rd_valid", 32'(rd_valid), 32'h0);
        chk("unmapped_rd_hold", 32'(rd_data), 32'h003C);

        key_n = 4'b1011;
        for (int i = 0; i < 10; i++) tick();
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("key2_read", 32'(rd_data), 32'h0004);
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("key2_cleared", 32'(rd_data), 32'h0000);

        // Key 0 edge reaches the synchronised side exactly when the read is issued.
        key_n = 4'b1010;
        tick();
        tick();
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("coincident_read", 32'(rd_data), 32'h0000);
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("coincident_set_wins", 32'(rd_data), 32'h0001);
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("held_no_reset", 32'(rd_data), 32'h0000);

        key_n = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        key_n = 4'b1011;
        for (int i = 0; i < 4; i++) tick();
        bus(MREAD, ADDR_KEYSTAT, 16'h0000);
        chk("key2_repress", 32'(rd_data), 32'h0004);

`ifdef MMIO_CYCLE_COUNTER_EN
        mem_addr = ADDR_CYCLE;
        #1;
        chk("cycle_io_sel", 32'(io_sel), 32'h1);
        bus(MWRITE, ADDR_CYCLE, 16'hFFFE);
        tick();
        tick();
        bus(MREAD, ADDR_CYCLE, 16'h0000);
        chk("cycle_valid", 32'(rd_valid), 32'h1);
        chk("cycle_wrap", 32'(rd_data), 32'h0000);
`else
        mem_addr = ADDR_CYCLE;
        #1;
        chk("cycle_unmapped_io_sel", 32'(io_sel), 32'h0);
        bus(MREAD, ADDR_CYCLE, 16'h0000);
        chk("cycle_unmapped_valid", 32'(rd_valid), 32'h0);
`endif

        reset = 1'b1;
        bus(MWRITE, ADDR_LED, 16'h0055);
        chk("reset_overrides_led", 32'(led_out), 32'h00);
        chk("reset_clears_hex", 32'(hex_value), 32'h0000);
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
